add_sub_seq: RTL and testbench

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

---
 rtl/add_sub_seq.sv | 118 +++++++++++
 tb/tb_add_sub_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/add_sub_seq.sv
// Sequential adder/subtractor: accepts one operand pair, then resolves it one
// 4-bit carry-lookahead slice per cycle from LSB to MSB before presenting the result.
module add_sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICES = WIDTH / 4;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0]    LAST = CW'(SLICES - 1);
  localparam logic [WIDTH-1:0] NIB  = WIDTH'(4'hF);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic [CW+1:0]    base;
  logic [3:0]       sa;
  logic [3:0]       sb;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [3:0]       sum;
  logic [4:0]       c;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Current slice selected by shifting, so the bit offset never needs a variable part-select.
  assign base = {cnt, 2'b00};
  assign sa   = 4'(a_q >> base);
  assign sb   = 4'(b_q >> base);
  assign g    = sa & sb;
  assign p    = sa ^ sb;

  // All four slice carries are resolved in parallel from the registered slice carry-in.
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sum  = p ^ c[3:0];

  assign res_next = (res_q & ~(NIB << base)) | (WIDTH'(sum) << base);

  // NOTE: operand and partial-result registers carry no reset; each operation
  // loads or overwrites them before any bit is read, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= ctrl ? ~b : b;
    end
    if (state == BUSY) begin
      res_q <= res_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= ctrl ? ~cin : cin;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          carry <= c[4];
          if (cnt == LAST) begin
            s     <= res_next;
            cout  <= c[4];
            ovf   <= c[3] ^ c[4];
            zero  <= (res_next == '0);
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed and randomized checks of add_sub_seq at WIDTH = 4, 16 and 32.
module tb_add_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        ctrl;
  logic        out_ready;
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  co;
  logic [2:0]  vf;
  logic [2:0]  zr;
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [31:0] s_sel;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign iv = in_valid ? (3'b001 << sel) : 3'b000;

  always_comb begin
    s_sel = '0;
    case (sel)
      2'd0:    s_sel = {28'd0, s4};
      2'd1:    s_sel = {16'd0, s16};
      default: s_sel = s32;
    endcase
  end

  add_sub_seq #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[3:0]), .b(b[3:0]),
    .cin(cin), .ctrl(ctrl), .out_valid(ov[0]), .out_ready(out_ready), .s(s4),
    .cout(co[0]), .ovf(vf[0]), .zero(zr[0]));

  add_sub_seq #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .ctrl(ctrl), .out_valid(ov[1]), .out_ready(out_ready), .s(s16),
    .cout(co[1]), .ovf(vf[1]), .zero(zr[1]));

  add_sub_seq #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b),
    .cin(cin), .ctrl(ctrl), .out_valid(ov[2]), .out_ready(out_ready), .s(s32),
    .cout(co[2]), .ovf(vf[2]), .zero(zr[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int width_of(input logic [1:0] k);
    return (k == 2'd0) ? 4 : (k == 2'd1) ? 16 : 32;
  endfunction

  // Reference: wide arithmetic, then signed overflow from operand/result signs.
  task automatic model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                       input logic mcin, input logic mctrl,
                       output logic [31:0] es, output logic ec, output logic ev, output logic ez);
    logic [63:0] mask;
    logic [63:0] av;
    logic [63:0] bv;
    logic [63:0] full;
    mask = (64'd1 << w) - 64'd1;
    av   = {32'd0, ma} & mask;
    bv   = {32'd0, mb} & mask;
    if (mctrl) begin
      bv   = ~bv & mask;
      full = av + bv + {63'd0, ~mcin};
    end else begin
      full = av + bv + {63'd0, mcin};
    end
    es = 32'(full & mask);
    ec = full[w];
    ev = (av[w-1] == bv[w-1]) && (es[w-1] != av[w-1]);
    ez = (es == 32'd0);
  endtask

  // Issues one operation to instance k, scrambles the inputs right after
  // acceptance, then checks latency and all result fields.
  task automatic do_op(input string tag, input logic [1:0] k,
                       input logic [31:0] oa, input logic [31:0] ob, input logic oc, input logic op,
                       input logic [31:0] es, input logic ec, input logic ev, input logic ez);
    int n;
    sel = k;
    n = 0;
    while (!ir[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    a = oa; b = ob; cin = oc; ctrl = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~oa; b = ~ob; cin = ~oc; ctrl = ~op;
    n = 0;
    while (!ov[k] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 64'(n), 64'(width_of(k) / 4));
    check({tag, " s"}, {32'd0, s_sel}, {32'd0, es});
    check({tag, " cout"}, {63'd0, co[k]}, {63'd0, ec});
    check({tag, " ovf"}, {63'd0, vf[k]}, {63'd0, ev});
    check({tag, " zero"}, {63'd0, zr[k]}, {63'd0, ez});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"}, {61'd0, ir}, 64'h7);
    check({tag, " out_valid"}, {61'd0, ov}, 64'h0);
    check({tag, " s"}, {28'd0, s4, s16}, 64'h0);
    check({tag, " s32"}, {32'd0, s32}, 64'h0);
    check({tag, " flags"}, {55'd0, co, vf, zr}, 64'h0);
  endtask

  initial begin
    logic [31:0] es;
    logic        ec;
    logic        ev;
    logic        ez;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rop;

    rst = 1'b1; in_valid = 1'b0; sel = 2'd1; a = '0; b = '0; cin = 1'b0; ctrl = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // Directed vectors at WIDTH = 16 with hand-computed results.
    do_op("add_1234_0fff", 2'd1, 32'h1234, 32'h0FFF, 1'b0, 1'b0, 32'h2233, 1'b0, 1'b0, 1'b0);
    do_op("add_ffff_0001", 2'd1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1);
    do_op("add_7fff_0001", 2'd1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0);
    do_op("sub_0005_0007", 2'd1, 32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op("sub_8000_0001", 2'd1, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0);
    do_op("sub_0010_0003_b", 2'd1, 32'h0010, 32'h0003, 1'b1, 1'b1, 32'h000C, 1'b1, 1'b0, 1'b0);
    do_op("add_w4_9_8_c", 2'd0, 32'h9, 32'h8, 1'b1, 1'b0, 32'h2, 1'b1, 1'b1, 1'b0);
    do_op("sub_w32_0_1", 2'd2, 32'h0, 32'h1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held, in_ready low, extra requests ignored.
    out_ready = 1'b0;
    do_op("bp", 2'd1, 32'h4321, 32'h1111, 1'b0, 1'b0, 32'h5432, 1'b0, 1'b0, 1'b0);
    a = 32'h0101; b = 32'h0202; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold out_valid", {63'd0, ov[1]}, 64'h1);
      check("bp hold s", {48'd0, s16}, 64'h5432);
      check("bp hold in_ready", {63'd0, ir[1]}, 64'h0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready", {63'd0, ir[1]}, 64'h1);
    check("bp release out_valid", {63'd0, ov[1]}, 64'h0);
    check("bp idle keeps s", {48'd0, s16}, 64'h5432);
    repeat (6) @(posedge clk);
    #1 check("bp no queued op", {63'd0, ov[1]}, 64'h0);

    // Reset in the second BUSY cycle aborts the operation.
    sel = 2'd1; a = 32'h1000; b = 32'h2000; cin = 1'b0; ctrl = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("abort");
    repeat (6) @(posedge clk);
    #1 check("abort no result", {63'd0, ov[1]}, 64'h0);
    do_op("after_abort", 2'd1, 32'hABCD, 32'h1234, 1'b1, 1'b1, 32'h9998, 1'b1, 1'b0, 1'b0);

    // Randomized run against the reference model at every width.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom; rb = $urandom;
        rc = 1'($urandom_range(1)); rop = 1'($urandom_range(1));
        if (i % 50 == 0) rb = ra;
        model(width_of(2'(k)), ra, rb, rc, rop, es, ec, ev, ez);
        do_op($sformatf("rand_w%0d_%0d", width_of(2'(k)), i), 2'(k), ra, rb, rc, rop,
              es, ec, ev, ez);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
